// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep sequencer.
package tt_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      CMP  = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int SETTLE_MAX = 15;

   function automatic logic [31:0] gray(input logic [31:0] s);
      return s ^ (s >> 1);
   endfunction

   function automatic int tt_width(input int n_in, input int n_out);
      return n_out * (2 ** n_in);
   endfunction

endpackage

// File: rtl/tt_popcount.sv
// Combinational population count of a W-bit vector; zero latency, no flow control.
module tt_popcount #(
   parameter int W = 8
) (
   input  logic [W-1:0]           vec_i,
   output logic [$clog2(W+1)-1:0] cnt_o
);

   localparam int CW = $clog2(W + 1);

   always_comb begin
      cnt_o = '0;
      for (int i = 0; i < W; i++) begin
         cnt_o = cnt_o + CW'(vec_i[i]);
      end
   end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive input sweep of a combinational netlist with truth-table capture and compare.
// Done pulses 2**N_IN*(SETTLE+1)+2 cycles after start; TT_SWEEP_GRAY_EN selects Gray vector order.
module tt_sweep_ctrl
   import tt_sweep_pkg::*;
#(
   parameter  int unsigned N_IN   = 4,
   parameter  int unsigned N_OUT  = 2,
   parameter  int unsigned SETTLE = 1,
   localparam int          TT_W   = tt_width(N_IN, N_OUT),
   localparam int          EW     = $clog2(TT_W + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic [N_IN-1:0]   vec_o,
   input  logic [N_OUT-1:0]  f_i,
   input  logic [TT_W-1:0]   exp_tt_i,
   output logic              busy,
   output logic              done,
   output logic [TT_W-1:0]   tt_o,
   output logic [EW-1:0]     err_cnt,
   output logic              mismatch
);

   localparam int              NV     = 2 ** N_IN;
   localparam int              CNT_W  = $clog2(SETTLE_MAX + 1);
   localparam logic [CNT_W-1:0] SET_C = CNT_W'(SETTLE);
   localparam logic [N_IN-1:0] LAST   = '1;

   state_e            state_q, state_d;
   logic [N_IN-1:0]   vec_q, vec_d;
   logic [N_IN-1:0]   step_q, step_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TT_W-1:0]   tt_q, tt_d;
   logic [EW-1:0]     err_q, err_d;
   logic              mis_q, mis_d;
   logic [EW-1:0]     pop_cnt;

   function automatic logic [N_IN-1:0] order(input logic [N_IN-1:0] s);
`ifdef TT_SWEEP_GRAY_EN
      return N_IN'(gray(32'(s)));
`else
      return s;
`endif
   endfunction

   tt_popcount #(.W(TT_W)) u_popcount (
      .vec_i (tt_q ^ exp_tt_i),
      .cnt_o (pop_cnt)
   );

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      step_d  = step_q;
      cnt_d   = cnt_q;
      tt_d    = tt_q;
      err_d   = err_q;
      mis_d   = mis_q;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               tt_d    = '0;
               err_d   = '0;
               mis_d   = 1'b0;
               step_d  = '0;
               cnt_d   = '0;
               vec_d   = order('0);
               state_d = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (cnt_q < SET_C) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               // Capture index follows the applied vector, so order never affects tt layout.
               for (int j = 0; j < int'(N_OUT); j++) begin
                  for (int v = 0; v < NV; v++) begin
                     if (vec_q == N_IN'(v)) tt_d[j*NV + v] = f_i[j];
                  end
               end
               if (step_q == LAST) begin
                  state_d = CMP;
               end else begin
                  step_d = step_q + 1'b1;
                  vec_d  = order(step_q + 1'b1);
                  cnt_d  = '0;
               end
            end
         end
         CMP: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               err_d   = pop_cnt;
               mis_d   = (pop_cnt != '0);
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vec_q   <= '0;
         step_q  <= '0;
         cnt_q   <= '0;
         tt_q    <= '0;
         err_q   <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         tt_q    <= tt_d;
         err_q   <= err_d;
         mis_q   <= mis_d;
      end
   end

   assign vec_o    = vec_q;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign tt_o     = tt_q;
   assign err_cnt  = err_q;
   assign mismatch = mis_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: two instances (SETTLE=0 and SETTLE=2) driven by table-lookup netlist stubs.
module tb_tt_sweep_ctrl;

   localparam int NV = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_r [2];
   logic        abort_r [2];
   logic [31:0] net_r   [2];
   logic [31:0] exp_r   [2];
   logic [3:0]  vec_w   [2];
   logic [1:0]  f_w     [2];
   logic        busy_w  [2];
   logic        done_w  [2];
   logic [31:0] tt_w    [2];
   logic [5:0]  err_w   [2];
   logic        mis_w   [2];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign f_w[0] = {net_r[0][16 + int'(vec_w[0])], net_r[0][int'(vec_w[0])]};
   assign f_w[1] = {net_r[1][16 + int'(vec_w[1])], net_r[1][int'(vec_w[1])]};

   tt_sweep_ctrl #(.N_IN(4), .N_OUT(2), .SETTLE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_r[0]), .abort(abort_r[0]),
      .vec_o(vec_w[0]), .f_i(f_w[0]), .exp_tt_i(exp_r[0]), .busy(busy_w[0]),
      .done(done_w[0]), .tt_o(tt_w[0]), .err_cnt(err_w[0]), .mismatch(mis_w[0])
   );

   tt_sweep_ctrl #(.N_IN(4), .N_OUT(2), .SETTLE(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start_r[1]), .abort(abort_r[1]),
      .vec_o(vec_w[1]), .f_i(f_w[1]), .exp_tt_i(exp_r[1]), .busy(busy_w[1]),
      .done(done_w[1]), .tt_o(tt_w[1]), .err_cnt(err_w[1]), .mismatch(mis_w[1])
   );

   function automatic logic [3:0] order_m(input int s);
`ifdef TT_SWEEP_GRAY_EN
      return 4'(s ^ (s >> 1));
`else
      return 4'(s);
`endif
   endfunction

   function automatic int diff_bits(input logic [31:0] a, input logic [31:0] b);
      int c = 0;
      for (int i = 0; i < 32; i++) if (a[i] != b[i]) c++;
      return c;
   endfunction

   task automatic run_sweep(input int d, input logic [31:0] net, input logic [31:0] expv,
                            input bit mid, input string tag);
      int s, lat, got, want_err;
      logic [3:0] ev;
      s        = (d == 0) ? 0 : 2;
      lat      = NV * (s + 1) + 2;
      want_err = diff_bits(net, expv);
      net_r[d] = net;
      exp_r[d] = expv;
      start_r[d] = 1'b1;
      got = 0;
      for (int n = 1; n <= lat + 20; n++) begin
         @(posedge clk); #1;
         start_r[d] = mid && (n == 7);
         if (n == 1) begin
            checks++;
            if (tt_w[d] !== 32'h0 || err_w[d] !== 6'd0 || mis_w[d] !== 1'b0) begin
               errors++;
               $display("FAIL %s clear_at_start: tt=%h err=%0d mis=%b, want 0", tag, tt_w[d], err_w[d], mis_w[d]);
            end
         end
         if (n <= NV * (s + 1)) begin
            ev = order_m((n - 1) / (s + 1));
            checks++;
            if (vec_w[d] !== ev) begin
               errors++;
               $display("FAIL %s vec_seq cycle %0d: got %0d want %0d", tag, n, vec_w[d], ev);
            end
         end
         if (done_w[d] === 1'b1) begin
            got = n;
            break;
         end
         checks++;
         if (busy_w[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s busy cycle %0d: got %b want 1", tag, n, busy_w[d]);
         end
      end
      checks++;
      if (got != lat) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d (0 = timeout)", tag, got, lat);
      end
      checks++;
      if (tt_w[d] !== net) begin
         errors++;
         $display("FAIL %s tt: got %h want %h", tag, tt_w[d], net);
      end
      checks++;
      if (err_w[d] !== 6'(want_err) || mis_w[d] !== (want_err != 0)) begin
         errors++;
         $display("FAIL %s err_cnt: got %0d/%b want %0d/%b", tag, err_w[d], mis_w[d], want_err, want_err != 0);
      end
      @(posedge clk); #1;
      checks++;
      if (busy_w[d] !== 1'b0 || done_w[d] !== 1'b0 || tt_w[d] !== net || err_w[d] !== 6'(want_err)) begin
         errors++;
         $display("FAIL %s after_done: busy=%b done=%b tt=%h err=%0d want 0/0/%h/%0d",
                  tag, busy_w[d], done_w[d], tt_w[d], err_w[d], net, want_err);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         start_r[d] = 1'b1;
         abort_r[d] = 1'b0;
         net_r[d]   = 32'h8000_6666;
         exp_r[d]   = 32'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (vec_w[d] !== 4'd0 || busy_w[d] !== 1'b0 || done_w[d] !== 1'b0 ||
             tt_w[d] !== 32'h0 || err_w[d] !== 6'd0 || mis_w[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset dut%0d: vec=%0d busy=%b done=%b tt=%h err=%0d mis=%b, want all 0",
                     d, vec_w[d], busy_w[d], done_w[d], tt_w[d], err_w[d], mis_w[d]);
         end
         start_r[d] = 1'b0;
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy_w[0] !== 1'b0 || busy_w[1] !== 1'b0) begin
         errors++;
         $display("FAIL reset_release busy: got %b%b want 00", busy_w[0], busy_w[1]);
      end
   endtask

   task automatic test_abort();
      int hit = 0;
      int dones = 0;
      net_r[0] = 32'h8000_6666;
      exp_r[0] = 32'h8000_6666;
      start_r[0] = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         start_r[0] = 1'b0;
         if (vec_w[0] === order_m(5)) begin
            hit = 1;
            break;
         end
      end
      abort_r[0] = 1'b1;
      @(posedge clk); #1;
      abort_r[0] = 1'b0;
      checks++;
      if (hit == 0 || busy_w[0] !== 1'b0 || vec_w[0] !== order_m(5)) begin
         errors++;
         $display("FAIL abort_state: reached=%0d busy=%b vec=%0d want 1/0/%0d", hit, busy_w[0], vec_w[0], order_m(5));
      end
      checks++;
      if ((tt_w[0] & 32'hFFC0_FFC0) !== 32'h0 || (tt_w[0] & 32'h001F_001F) !== (32'h8000_6666 & 32'h001F_001F)) begin
         errors++;
         $display("FAIL abort_partial_tt: got %h want steps 0..4 of 80006666 only", tt_w[0]);
      end
      for (int n = 0; n < 30; n++) begin
         @(posedge clk); #1;
         if (done_w[0] === 1'b1 || busy_w[0] === 1'b1) dones++;
      end
      checks++;
      if (dones != 0) begin
         errors++;
         $display("FAIL abort_no_done: busy/done cycles %0d want 0", dones);
      end
      run_sweep(0, 32'h8000_6666, 32'h8000_6666, 1'b0, "abort_restart");
   endtask

   task automatic test_idle_controls();
      logic [31:0] held;
      held = tt_w[1];
      abort_r[1] = 1'b1;
      start_r[1] = 1'b1;
      @(posedge clk); #1;
      abort_r[1] = 1'b0;
      start_r[1] = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy_w[1] !== 1'b0 || tt_w[1] !== held) begin
         errors++;
         $display("FAIL idle_abort_start: busy=%b tt=%h want 0/%h", busy_w[1], tt_w[1], held);
      end
   endtask

   task automatic test_random();
      int d;
      logic [31:0] net, expv;
      for (int k = 0; k < 6; k++) begin
         d    = int'($urandom_range(0, 1));
         net  = $urandom;
         expv = (k % 2 == 0) ? (net ^ (32'h1 << $urandom_range(0, 31))) : $urandom;
         run_sweep(d, net, expv, 1'b0, "random");
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
   endtask

   initial begin
      test_reset();
      run_sweep(0, 32'h8000_6666, 32'h8000_6666, 1'b0, "basic");
      run_sweep(1, 32'h8000_6666, 32'h8000_6667, 1'b0, "settle2");
      run_sweep(0, 32'h8000_6666, 32'h0000_0000, 1'b0, "zero_exp");
      test_abort();
      run_sweep(1, 32'h8000_6666, 32'h8000_6666, 1'b1, "mid_start");
      test_idle_controls();
      test_random();
      test_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
